// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: memory-controller side of the DDR3 app_* interface.
// An on-chip array stands in for the DDR3 device. Commands and write data are
// queued separately, executed strictly in order, and reads return after a fixed latency.
// Optional build macro: DDR3_RESP_REFRESH_EN adds periodic refresh stalls.
module ddr3_app_responder #(
    parameter int unsigned APP_ADDR_WIDTH   = 29,
    parameter int unsigned DATA_WIDTH       = 128,
    parameter int unsigned MEM_DEPTH_LOG2   = 10,
    parameter int unsigned CMD_FIFO_DEPTH   = 4,
    parameter int unsigned WDF_FIFO_DEPTH   = 4,
    parameter int unsigned READ_LATENCY     = 8,
    parameter int unsigned CALIB_CYCLES     = 64,
    parameter int unsigned REFRESH_INTERVAL = 512,
    parameter int unsigned REFRESH_CYCLES   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APP_ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]                app_cmd,
    input  logic                      app_en,
    output logic                      app_rdy,
    input  logic [DATA_WIDTH-1:0]     app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    output logic                      app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]     app_rd_data,
    output logic                      app_rd_data_valid,
    output logic                      app_rd_data_end,
    output logic                      init_calib_complete,
    output logic                      illegal_cmd
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CMD_PW     = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int unsigned CMD_CW     = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int unsigned WDF_PW     = (WDF_FIFO_DEPTH > 1) ? $clog2(WDF_FIFO_DEPTH) : 1;
    localparam int unsigned WDF_CW     = $clog2(WDF_FIFO_DEPTH + 1);
    localparam int unsigned CAL_W      = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned PIPE_LEN   = READ_LATENCY - 1;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef struct packed {
        logic [MEM_DEPTH_LOG2-1:0] idx;
        logic [2:0]                cmd;
    } cmd_entry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
    } wdf_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    cmd_entry_t            cmd_q [CMD_FIFO_DEPTH];
    logic [CMD_PW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
    logic [CMD_CW-1:0]     cmd_cnt;
    wdf_entry_t            wdf_q [WDF_FIFO_DEPTH];
    logic [WDF_PW-1:0]     wdf_wr_ptr, wdf_rd_ptr;
    logic [WDF_CW-1:0]     wdf_cnt;

    logic [CAL_W-1:0]      cal_cnt;
    logic                  refresh_busy;
    state_t                state, state_nx;

    logic                  cmd_full, cmd_empty, wdf_full, wdf_empty;
    logic                  cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic                  exec_rd, exec_wr, exec_ill;
    cmd_entry_t            cmd_head;
    wdf_entry_t            wdf_head;

    logic [PIPE_LEN-1:0]   pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_data [PIPE_LEN];

    // Address offset bits, wrapped upper bits and the burst-end marker carry no function here
    logic unused_inputs;
    assign unused_inputs = ^{app_addr, app_wdf_end};

    assign cmd_full  = (cmd_cnt == CMD_CW'(CMD_FIFO_DEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign wdf_full  = (wdf_cnt == WDF_CW'(WDF_FIFO_DEPTH));
    assign wdf_empty = (wdf_cnt == '0);

    assign app_rdy     = init_calib_complete && !cmd_full && !refresh_busy;
    assign app_wdf_rdy = init_calib_complete && !wdf_full;
    assign cmd_push    = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;
    assign cmd_head    = cmd_q[cmd_rd_ptr];
    assign wdf_head    = wdf_q[wdf_rd_ptr];

    // Calibration timer: counts clock edges after reset release, then latches done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_cnt             <= '0;
            init_calib_complete <= 1'b0;
        end else if (!init_calib_complete) begin
            if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                init_calib_complete <= 1'b1;
            end else begin
                cal_cnt <= cal_cnt + 1'b1;
            end
        end
    end

`ifdef DDR3_RESP_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REFRESH_INTERVAL);
    logic [REF_W-1:0] ref_cnt;

    // Free-running refresh period counter; the last REFRESH_CYCLES of each period stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
        end else if (init_calib_complete) begin
            ref_cnt <= (ref_cnt == REF_W'(REFRESH_INTERVAL - 1)) ? '0 : ref_cnt + 1'b1;
        end
    end

    assign refresh_busy = init_calib_complete &&
                          (ref_cnt >= REF_W'(REFRESH_INTERVAL - REFRESH_CYCLES));
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = ^{32'(REFRESH_INTERVAL), 32'(REFRESH_CYCLES)};
    assign refresh_busy       = 1'b0;
`endif

    // Command and write-data FIFO storage (no reset needed on payload)
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_q[cmd_wr_ptr] <= '{idx: app_addr[MEM_DEPTH_LOG2+2:3], cmd: app_cmd};
        end
        if (wdf_push) begin
            wdf_q[wdf_wr_ptr] <= '{data: app_wdf_data, mask: app_wdf_mask};
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
            wdf_wr_ptr <= '0;
            wdf_rd_ptr <= '0;
            wdf_cnt    <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
            else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - 1'b1;
            if (wdf_push) wdf_wr_ptr <= wdf_wr_ptr + 1'b1;
            if (wdf_pop)  wdf_rd_ptr <= wdf_rd_ptr + 1'b1;
            if (wdf_push && !wdf_pop)      wdf_cnt <= wdf_cnt + 1'b1;
            else if (!wdf_push && wdf_pop) wdf_cnt <= wdf_cnt - 1'b1;
        end
    end

    // Execution engine next-state and per-cycle action strobes
    always_comb begin
        state_nx = state;
        exec_rd  = 1'b0;
        exec_wr  = 1'b0;
        exec_ill = 1'b0;
        cmd_pop  = 1'b0;
        wdf_pop  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!cmd_empty) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (!refresh_busy) begin
                    if (cmd_head.cmd == CMD_RD) begin
                        exec_rd = 1'b1;
                        cmd_pop = 1'b1;
                    end else if (cmd_head.cmd == CMD_WR) begin
                        if (!wdf_empty) begin
                            exec_wr = 1'b1;
                            cmd_pop = 1'b1;
                            wdf_pop = 1'b1;
                        end else begin
                            state_nx = ST_WAIT_DATA;
                        end
                    end else begin
                        exec_ill = 1'b1;
                        cmd_pop  = 1'b1;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (!refresh_busy && !wdf_empty) begin
                    exec_wr = 1'b1;
                    cmd_pop = 1'b1;
                    wdf_pop = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (cmd_pop) begin
            state_nx = (cmd_cnt == CMD_CW'(1) && !cmd_push) ? ST_IDLE : ST_EXEC;
        end
    end

    // Engine state and sticky illegal-command flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            illegal_cmd <= 1'b0;
        end else begin
            state <= state_nx;
            if (exec_ill) illegal_cmd <= 1'b1;
        end
    end

    // Byte-masked array write; a set mask bit preserves that byte
    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < int'(MASK_WIDTH); b++) begin
                if (!wdf_head.mask[b]) begin
                    mem[cmd_head.idx][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
                end
            end
        end
    end

    // Read data pipeline; each stage holds its data until a new valid passes through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < int'(PIPE_LEN); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= exec_rd;
            if (exec_rd) pipe_data[0] <= mem[cmd_head.idx];
            for (int i = 1; i < int'(PIPE_LEN); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign app_rd_data       = pipe_data[PIPE_LEN-1];
    assign app_rd_data_valid = pipe_vld[PIPE_LEN-1];
    assign app_rd_data_end   = pipe_vld[PIPE_LEN-1];

endmodule
